spi_master_arbiter: RTL and testbench

Shares one `spi_master_ss` DAC channel between several requesters: the control loop, the CPU-side raw DAC access path, and future scan logic. Each requester sees the same arm/finished/to_slave/from_slave handshake the SPI master exposes. The block instantiates no SPI logic; it sits between the requesters and the single master. It grants the channel round-robin and can optionally hold it for multi-transfer sequences such as the DAC read-back command followed by a NOP clock-out.

---
 rtl/spi_master_arbiter_pkg.sv | 11 +
 rtl/spi_master_arbiter_rr_select.sv | 24 ++
 rtl/spi_master_arbiter.sv | 117 +++++++++++
 tb/tb_spi_master_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_arbiter_pkg.sv
// spi_master_arbiter_pkg: FSM state encodings shared by the arbiter files
package spi_master_arbiter_pkg;
  localparam int STATESIZ = 3;
  typedef enum logic [STATESIZ-1:0] {
    IDLE    = 3'd0,
    XFER    = 3'd1,
    DONE    = 3'd2,
    RELEASE = 3'd3,
    HOLD    = 3'd4
  } state_t;
endpackage

// File: rtl/spi_master_arbiter_rr_select.sv
// rr_select: first set request bit at or after a pointer, wrapping modulo N
module rr_select
  import spi_master_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_found
);
  // scan offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[(int'(i_ptr) + i) % N]) begin
        o_idx   = W'((int'(i_ptr) + i) % N);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master among requesters
// Optional grant hold across transfers: define SPI_MASTER_ARBITER_LOCK_EN
module spi_master_arbiter
  import spi_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int REQ_SIZ = 1,
  parameter int WID     = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_arm,
  input  logic [NUM_REQ*WID-1:0] req_to_slave,
  input  logic [NUM_REQ-1:0]     req_lock,
  output logic [NUM_REQ-1:0]     req_finished,
  output logic [WID-1:0]         req_from_slave,
  output logic                   mst_arm,
  output logic [WID-1:0]         mst_to_slave,
  input  logic                   mst_finished,
  input  logic [WID-1:0]         mst_from_slave,
  output logic                   grant_valid,
  output logic [REQ_SIZ-1:0]     grant_idx
);
  state_t               r_state;
  logic [REQ_SIZ-1:0]   r_rr_ptr;
  logic [REQ_SIZ-1:0]   r_grant_idx;
  logic                 r_grant_valid;
  logic                 r_mst_arm;
  logic [WID-1:0]       r_mst_to_slave;
  logic [NUM_REQ-1:0]   r_req_finished;
  logic [WID-1:0]       r_req_from_slave;
  logic [REQ_SIZ-1:0]   w_sel;
  logic                 w_found;
  logic [REQ_SIZ-1:0]   w_next;
  logic [WID-1:0]       w_sel_word;
  logic [WID-1:0]       w_own_word;
  logic                 w_own_arm;
  rr_select #(.N(NUM_REQ), .W(REQ_SIZ)) u_sel (
    .i_req  (req_arm),
    .i_ptr  (r_rr_ptr),
    .o_idx  (w_sel),
    .o_found(w_found)
  );
  assign w_next     = (r_grant_idx == REQ_SIZ'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
  assign w_sel_word = req_to_slave[int'(w_sel) * WID +: WID];
  assign w_own_word = req_to_slave[int'(r_grant_idx) * WID +: WID];
  assign w_own_arm  = req_arm[r_grant_idx];
`ifndef SPI_MASTER_ARBITER_LOCK_EN
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;
`endif
  assign req_finished   = r_req_finished;
  assign req_from_slave = r_req_from_slave;
  assign mst_arm        = r_mst_arm;
  assign mst_to_slave   = r_mst_to_slave;
  assign grant_valid    = r_grant_valid;
  assign grant_idx      = r_grant_idx;
  // grant FSM: every output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_rr_ptr         <= '0;
      r_grant_idx      <= '0;
      r_grant_valid    <= 1'b0;
      r_mst_arm        <= 1'b0;
      r_mst_to_slave   <= '0;
      r_req_finished   <= '0;
      r_req_from_slave <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_mst_to_slave <= w_sel_word;
          r_grant_idx    <= w_sel;
          r_grant_valid  <= 1'b1;
          r_mst_arm      <= 1'b1;
          r_state        <= XFER;
        end
        XFER: if (mst_finished) begin
          r_req_from_slave <= mst_from_slave;
          r_req_finished   <= NUM_REQ'(1) << r_grant_idx;
          r_state          <= DONE;
        end
        DONE: if (!w_own_arm) begin
          r_mst_arm      <= 1'b0;
          r_req_finished <= '0;
          r_state        <= RELEASE;
        end
        RELEASE: if (!mst_finished) begin
`ifdef SPI_MASTER_ARBITER_LOCK_EN
          if (req_lock[r_grant_idx]) r_state <= HOLD;
          else begin
            r_rr_ptr      <= w_next;
            r_grant_valid <= 1'b0;
            r_state       <= IDLE;
          end
`else
          r_rr_ptr      <= w_next;
          r_grant_valid <= 1'b0;
          r_state       <= IDLE;
`endif
        end
`ifdef SPI_MASTER_ARBITER_LOCK_EN
        HOLD: if (w_own_arm) begin
          r_mst_to_slave <= w_own_word;
          r_mst_arm      <= 1'b1;
          r_state        <= XFER;
        end else if (!req_lock[r_grant_idx]) begin
          r_rr_ptr      <= w_next;
          r_grant_valid <= 1'b0;
          r_state       <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_arm;
  logic [47:0] req_to_slave;
  logic [1:0]  req_lock;
  logic [1:0]  req_finished;
  logic [23:0] req_from_slave;
  logic        mst_arm;
  logic [23:0] mst_to_slave;
  logic        mst_finished;
  logic [23:0] mst_from_slave;
  logic        grant_valid;
  logic [0:0]  grant_idx;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat = 30;
  int          mcnt = 0;
  logic [23:0] resp = 24'h0F00F0;
  int          gcnt = 0;
  int          viol = 0;
  logic        glog [64];
  logic [23:0] wlog [64];
  logic        prev_arm = 1'b0;
  spi_master_arbiter #(.NUM_REQ(2), .REQ_SIZ(1), .WID(24)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_arm       (req_arm),
    .req_to_slave  (req_to_slave),
    .req_lock      (req_lock),
    .req_finished  (req_finished),
    .req_from_slave(req_from_slave),
    .mst_arm       (mst_arm),
    .mst_to_slave  (mst_to_slave),
    .mst_finished  (mst_finished),
    .mst_from_slave(mst_from_slave),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx)
  );
  always #5 clk = ~clk;
  // SPI master model: finishes lat cycles after arm, drops finished once arm falls
  initial begin
    mst_finished   = 1'b0;
    mst_from_slave = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mst_arm) begin
        mcnt = 0;
        mst_finished = 1'b0;
      end else if (!mst_finished) begin
        mcnt++;
        if (mcnt >= lat) begin
          mst_finished   = 1'b1;
          mst_from_slave = resp;
        end
      end
    end
  end
  // grant log on every new master arm, plus finished-to-non-owner watch
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mst_arm && !prev_arm && gcnt < 64) begin
        glog[gcnt] = grant_idx;
        wlog[gcnt] = mst_to_slave;
        gcnt++;
      end
      prev_arm = mst_arm;
      if ((req_finished & ~(grant_valid ? (2'b01 << grant_idx) : 2'b00)) != 2'b00) viol++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_arm = '0;
    req_lock = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic wait_fin(output int idx, output bit ok);
    ok = 1'b0;
    idx = -1;
    for (int c = 0; c < 200 && !ok; c++) begin
      tick();
      if (req_finished != 2'b00) begin
        ok = 1'b1;
        idx = req_finished[1] ? 1 : 0;
      end
    end
  endtask
  task automatic test_reset();
    req_to_slave = '0;
    do_reset();
    n_cmp++; if (mst_arm !== 1'b0) begin n_bad++; $display("FAIL reset_mst_arm: got %h want 0", mst_arm); end
    n_cmp++; if (mst_to_slave !== 24'h0) begin n_bad++; $display("FAIL reset_mst_to_slave: got %h want 0", mst_to_slave); end
    n_cmp++; if (req_finished !== 2'b00) begin n_bad++; $display("FAIL reset_req_finished: got %b want 00", req_finished); end
    n_cmp++; if (req_from_slave !== 24'h0) begin n_bad++; $display("FAIL reset_req_from_slave: got %h want 0", req_from_slave); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_grant_valid: got %h want 0", grant_valid); end
    n_cmp++; if (grant_idx !== 1'b0) begin n_bad++; $display("FAIL reset_grant_idx: got %h want 0", grant_idx); end
  endtask
  task automatic test_single();
    int idx;
    bit ok;
    do_reset();
    resp = 24'h0F00F0;
    req_to_slave[23:0] = 24'h1A2B3C;
    req_arm[0] = 1'b1;
    tick();
    n_cmp++; if (mst_arm !== 1'b1) begin n_bad++; $display("FAIL single_mst_arm: got %h want 1", mst_arm); end
    n_cmp++; if (grant_valid !== 1'b1) begin n_bad++; $display("FAIL single_grant_valid: got %h want 1", grant_valid); end
    n_cmp++; if (grant_idx !== 1'b0) begin n_bad++; $display("FAIL single_grant_idx: got %h want 0", grant_idx); end
    n_cmp++; if (mst_to_slave !== 24'h1A2B3C) begin n_bad++; $display("FAIL single_word: got %h want 1a2b3c", mst_to_slave); end
    req_to_slave[23:0] = 24'hFFFFFF;
    tick();
    n_cmp++; if (mst_to_slave !== 24'h1A2B3C) begin n_bad++; $display("FAIL single_word_held: got %h want 1a2b3c", mst_to_slave); end
    wait_fin(idx, ok);
    n_cmp++; if (!ok || idx != 0) begin n_bad++; $display("FAIL single_finish: got ok=%0d idx=%0d want ok=1 idx=0", ok, idx); end
    n_cmp++; if (req_finished !== 2'b01) begin n_bad++; $display("FAIL single_req_finished: got %b want 01", req_finished); end
    n_cmp++; if (req_from_slave !== 24'h0F00F0) begin n_bad++; $display("FAIL single_from_slave: got %h want 0f00f0", req_from_slave); end
    req_arm[0] = 1'b0;
    tick();
    n_cmp++; if (mst_arm !== 1'b0 || req_finished !== 2'b00) begin n_bad++; $display("FAIL single_release: got arm=%h fin=%b want arm=0 fin=00", mst_arm, req_finished); end
    tick();
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL single_grant_drop: got %h want 0", grant_valid); end
    req_to_slave = {24'h444444, 24'h333333};
    req_arm = 2'b11;
    tick();
    n_cmp++; if (grant_idx !== 1'b1 || mst_to_slave !== 24'h444444) begin n_bad++; $display("FAIL single_rr_ptr: got idx=%h word=%h want idx=1 word=444444", grant_idx, mst_to_slave); end
    wait_fin(idx, ok);
    req_arm[1] = 1'b0;
    wait_fin(idx, ok);
    n_cmp++; if (!ok || idx != 0) begin n_bad++; $display("FAIL single_rr_second: got ok=%0d idx=%0d want ok=1 idx=0", ok, idx); end
    req_arm[0] = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_contention();
    int idx;
    bit ok;
    do_reset();
    resp = 24'h5A5A5A;
    req_to_slave = {24'h222222, 24'h111111};
    req_arm = 2'b11;
    tick();
    n_cmp++; if (grant_idx !== 1'b0 || mst_to_slave !== 24'h111111) begin n_bad++; $display("FAIL cont_first: got idx=%h word=%h want idx=0 word=111111", grant_idx, mst_to_slave); end
    wait_fin(idx, ok);
    n_cmp++; if (!ok || req_finished !== 2'b01) begin n_bad++; $display("FAIL cont_fin0: got ok=%0d fin=%b want ok=1 fin=01", ok, req_finished); end
    req_arm[0] = 1'b0;
    repeat (3) tick();
    n_cmp++; if (grant_idx !== 1'b1 || mst_to_slave !== 24'h222222) begin n_bad++; $display("FAIL cont_second: got idx=%h word=%h want idx=1 word=222222", grant_idx, mst_to_slave); end
    wait_fin(idx, ok);
    n_cmp++; if (!ok || req_finished !== 2'b10 || req_from_slave !== 24'h5A5A5A) begin n_bad++; $display("FAIL cont_fin1: got ok=%0d fin=%b data=%h want ok=1 fin=10 data=5a5a5a", ok, req_finished, req_from_slave); end
    req_arm[1] = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_fairness();
    int idx;
    bit ok;
    int base;
    do_reset();
    base = gcnt;
    req_to_slave = {24'hBBBBBB, 24'hAAAAAA};
    req_arm = 2'b11;
    for (int t = 0; t < 6; t++) begin
      wait_fin(idx, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL fair_timeout: transfer %0d got none want finish", t); end
      if (ok) begin
        req_arm[idx] = 1'b0;
        tick();
        if (t < 5) req_arm[idx] = 1'b1;
      end
    end
    req_arm = 2'b00;
    repeat (4) tick();
    for (int t = 0; t < 6; t++) begin
      n_cmp++; if (glog[base + t] !== 1'(t % 2)) begin n_bad++; $display("FAIL fair_order: grant %0d got %h want %0d", t, glog[base + t], t % 2); end
    end
  endtask
  task automatic test_lock();
    int idx;
    bit ok;
    int base;
    logic        exp_g [3];
    logic [23:0] exp_w [3];
`ifdef SPI_MASTER_ARBITER_LOCK_EN
    exp_g = '{1'b0, 1'b0, 1'b1};
    exp_w = '{24'h900000, 24'h000000, 24'hABCDEF};
`else
    exp_g = '{1'b0, 1'b1, 1'b0};
    exp_w = '{24'h900000, 24'hABCDEF, 24'h000000};
`endif
    do_reset();
    base = gcnt;
    req_to_slave = {24'hABCDEF, 24'h900000};
    req_lock[0] = 1'b1;
    req_arm[0] = 1'b1;
    tick();
    req_arm[1] = 1'b1;
    wait_fin(idx, ok);
    n_cmp++; if (!ok || idx != 0) begin n_bad++; $display("FAIL lock_first: got ok=%0d idx=%0d want ok=1 idx=0", ok, idx); end
    req_arm[0] = 1'b0;
    repeat (3) tick();
    req_to_slave[23:0] = 24'h000000;
    req_arm[0] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      wait_fin(idx, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL lock_timeout: transfer %0d got none want finish", t); end
      if (ok) begin
        req_arm[idx] = 1'b0;
        if (idx == 0) req_lock[0] = 1'b0;
      end
    end
    repeat (4) tick();
    n_cmp++; if (gcnt - base != 3) begin n_bad++; $display("FAIL lock_count: got %0d want 3", gcnt - base); end
    for (int t = 0; t < 3; t++) begin
      n_cmp++; if (glog[base + t] !== exp_g[t] || wlog[base + t] !== exp_w[t]) begin n_bad++; $display("FAIL lock_order: grant %0d got idx=%h word=%h want idx=%h word=%h", t, glog[base + t], wlog[base + t], exp_g[t], exp_w[t]); end
    end
  endtask
  task automatic test_reset_mid();
    int idx;
    bit ok;
    resp = 24'h0C0FFE;
    req_to_slave = {24'h654321, 24'h123456};
    req_arm = 2'b01;
    repeat (5) tick();
    n_cmp++; if (mst_arm !== 1'b1 || req_from_slave === 24'h0) begin n_bad++; $display("FAIL rmid_pre: got arm=%h data=%h want arm=1 data nonzero", mst_arm, req_from_slave); end
    rst = 1'b1;
    req_arm = 2'b00;
    tick();
    rst = 1'b0;
    n_cmp++; if (mst_arm !== 1'b0 || grant_valid !== 1'b0 || grant_idx !== 1'b0) begin n_bad++; $display("FAIL rmid_ctl: got arm=%h gv=%h idx=%h want 0 0 0", mst_arm, grant_valid, grant_idx); end
    n_cmp++; if (mst_to_slave !== 24'h0 || req_from_slave !== 24'h0 || req_finished !== 2'b00) begin n_bad++; $display("FAIL rmid_data: got to=%h from=%h fin=%b want 0 0 00", mst_to_slave, req_from_slave, req_finished); end
    tick();
    req_arm[1] = 1'b1;
    tick();
    n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 1'b1 || mst_to_slave !== 24'h654321) begin n_bad++; $display("FAIL rmid_regrant: got gv=%h idx=%h word=%h want 1 1 654321", grant_valid, grant_idx, mst_to_slave); end
    wait_fin(idx, ok);
    n_cmp++; if (!ok || idx != 1 || req_from_slave !== 24'h0C0FFE) begin n_bad++; $display("FAIL rmid_finish: got ok=%0d idx=%0d data=%h want 1 1 0c0ffe", ok, idx, req_from_slave); end
    req_arm[1] = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_early_drop();
    int idx;
    bit ok;
    int base;
    do_reset();
    base = gcnt;
    req_to_slave = {24'h777777, 24'h666666};
    req_arm[0] = 1'b1;
    tick();
    req_arm[1] = 1'b1;
    tick();
    req_arm[1] = 1'b0;
    wait_fin(idx, ok);
    n_cmp++; if (!ok || idx != 0) begin n_bad++; $display("FAIL early_owner: got ok=%0d idx=%0d want ok=1 idx=0", ok, idx); end
    req_arm[0] = 1'b0;
    tick();
    tick();
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL early_release: got gv=%h want 0", grant_valid); end
    repeat (5) tick();
    n_cmp++; if (grant_valid !== 1'b0 || gcnt - base != 1) begin n_bad++; $display("FAIL early_never: got gv=%h grants=%0d want gv=0 grants=1", grant_valid, gcnt - base); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL nonowner_finished: got %0d cycles want 0", viol); end
  endtask
  initial begin
    rst = 1'b1;
    req_arm = '0;
    req_lock = '0;
    req_to_slave = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_lock();
    test_reset_mid();
    test_early_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
